// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-side sequencer with IR/MDR ownership and core stall generation
module mem_access_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_iord,
    input  logic        cpu_irwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        clk_en,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] mdr,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HALT} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          lat_iord;
    logic          lat_irwrite;

    // Non-memory control states run at full rate; DONE releases the core for one step.
    assign clk_en = !rst && ((state == S_IDLE && !cpu_req) || state == S_DONE);
    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            lat_iord    <= 1'b0;
            lat_irwrite <= 1'b0;
            instr       <= '0;
            mdr         <= '0;
            err         <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        lat_iord    <= cpu_iord;
                        lat_irwrite <= cpu_irwrite;
                        mem_req     <= 1'b1;
                        mem_we      <= cpu_we;
                        mem_addr    <= cpu_addr;
                        mem_wdata   <= cpu_wdata;
                        wait_cnt    <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        // mem_we still holds the latched write flag; stores capture nothing
                        if (!mem_we) begin
                            if (lat_irwrite && !lat_iord) begin
                                instr <= mem_rdata;
                            end else if (lat_iord) begin
                                mdr <= mem_rdata;
                            end
                        end
                        state <= S_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= S_HALT;
                    end else if (wait_cnt != CNT_SAT) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_HALT: begin
                    mem_req <= 1'b0;
                    state   <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_iord, cpu_irwrite;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        clk_en;
    logic [31:0] instr, mdr;
    logic [5:0]  opcode, funct;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [31:0] exp_instr, exp_mdr;

    always #5 clk = ~clk;

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_iord(cpu_iord), .cpu_irwrite(cpu_irwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .clk_en(clk_en), .instr(instr), .opcode(opcode), .funct(funct), .mdr(mdr), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        iord;
        logic        irwrite;
        int          delay;
        logic [31:0] rdata;
        int          exp_low;
        logic [31:0] exp_instr;
        logic [31:0] exp_mdr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // Enter and leave at posedge+1 with the DUT in IDLE (or HALT after a timeout).
    // The bench plays the memory: ack after `delay` request cycles, random junk otherwise.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic iord, input logic irwrite,
                           input int delay, input logic [31:0] rdata,
                           output int low_cycles, output bit saw_high, output int err_cycle);
        int waits = 0;
        bit hold_ok = 1'b1;
        low_cycles = 0;
        saw_high   = 1'b0;
        err_cycle  = -1;
        cpu_req = 1'b1; cpu_we = we; cpu_iord = iord; cpu_irwrite = irwrite;
        cpu_addr = addr; cpu_wdata = wdata;
        for (int cyc = 0; cyc < 16 && !saw_high; cyc++) begin
            if (mem_req) begin
                if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) hold_ok = 1'b0;
                mem_ack   = (waits == delay);
                mem_rdata = mem_ack ? rdata : $urandom();
                waits++;
            end else begin
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom();
            end
            #4;
            if (err && err_cycle < 0) err_cycle = cyc;
            if (clk_en) begin
                saw_high = 1'b1;
                if (mem_req !== 1'b0) hold_ok = 1'b0;
            end else begin
                low_cycles++;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        check({tag, " request hold"}, 32'(hold_ok), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_instr = '0;
        exp_mdr   = '0;
    endtask

    // Transaction-level reference: a read that completes updates IR or MDR, a timeout halts.
    task automatic model_and_check(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic we, input logic iord, input logic irwrite,
                                   input int delay, input logic [31:0] rdata);
        int  low, ecyc;
        bit  high;
        run_txn(tag, addr, wdata, we, iord, irwrite, delay, rdata, low, high, ecyc);
        if (delay < MW) begin
            if (!we && irwrite && !iord) exp_instr = rdata;
            else if (!we && iord)        exp_mdr   = rdata;
            check({tag, " stall cycles"}, 32'(low), 32'(delay + 2));
            check({tag, " instr"}, instr, exp_instr);
            check({tag, " mdr"}, mdr, exp_mdr);
            check({tag, " err"}, 32'(err), 32'd0);
        end else begin
            check({tag, " no advance"}, 32'(high), 32'd0);
            check({tag, " err cycle"}, 32'(ecyc), 32'(MW + 1));
            check({tag, " req dropped"}, 32'(mem_req), 32'd0);
            apply_reset();
        end
    endtask

    initial begin
        logic [31:0] op_src;
        int          low, ecyc;
        bit          high;

        vecs[0] = '{32'h40,  32'h0,        1'b0, 1'b0, 1'b1, 0, 32'h2008_0005, 2, 32'h2008_0005, 32'h0};
        vecs[1] = '{32'h100, 32'h0,        1'b0, 1'b1, 1'b0, 3, 32'hDEAD_BEEF, 5, 32'h2008_0005, 32'hDEAD_BEEF};
        vecs[2] = '{32'h200, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1, 32'hCAFE_F00D, 3, 32'h2008_0005, 32'hDEAD_BEEF};
        vecs[3] = '{32'h44,  32'h0,        1'b0, 1'b0, 1'b0, 2, 32'h1111_1111, 4, 32'h2008_0005, 32'hDEAD_BEEF};
        vecs[4] = '{32'h300, 32'h0,        1'b0, 1'b1, 1'b1, 0, 32'h8C22_0004, 2, 32'h2008_0005, 32'h8C22_0004};
        vecs[5] = '{32'h48,  32'h0,        1'b0, 1'b0, 1'b1, 1, 32'h012A_4020, 3, 32'h012A_4020, 32'h8C22_0004};
        vecs[6] = '{32'h4C,  32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 4, 32'h012A_4020, 32'h8C22_0004};

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_iord = 1'b0; cpu_irwrite = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        exp_instr = '0; exp_mdr = '0;
        #2;
        check("reset clk_en", 32'(clk_en), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset instr", instr, 32'h0);
        check("reset mdr", mdr, 32'h0);
        check("reset err", 32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we,
                    vecs[i].iord, vecs[i].irwrite, vecs[i].delay, vecs[i].rdata, low, high, ecyc);
            check($sformatf("vec%0d stall cycles", i), 32'(low), 32'(vecs[i].exp_low));
            check($sformatf("vec%0d advanced", i), 32'(high), 32'd1);
            check($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
            check($sformatf("vec%0d mdr", i), mdr, vecs[i].exp_mdr);
            op_src = vecs[i].exp_instr;
            check($sformatf("vec%0d opcode", i), 32'(opcode), 32'(op_src[31:26]));
            check($sformatf("vec%0d funct", i), 32'(funct), 32'(op_src[5:0]));
            if (i == 0) check("fetch mem_addr", mem_addr, 32'h40);
        end
        exp_instr = instr === vecs[6].exp_instr ? vecs[6].exp_instr : vecs[6].exp_instr;
        exp_mdr   = vecs[6].exp_mdr;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd, rd;
            logic        we, iord, irw;
            int          d;
            a    = $urandom() & 32'hFFFF_FFFC;
            wd   = $urandom();
            rd   = $urandom();
            we   = 1'($urandom_range(0, 1));
            iord = 1'($urandom_range(0, 1));
            irw  = we ? 1'b0 : 1'($urandom_range(0, 1));
            d    = ($urandom_range(0, 9) > 7) ? MW + int'($urandom_range(0, 2)) : int'($urandom_range(0, MW - 1));
            model_and_check($sformatf("rnd%0d", n), a, wd, we, iord, irw, d, rd);
        end

        for (int c = 0; c < 10; c++) begin
            cpu_req = 1'b0;
            #4;
            check($sformatf("pass clk_en %0d", c), 32'(clk_en), 32'd1);
            check($sformatf("pass mem_req %0d", c), 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end

        model_and_check("pre-reset fetch", 32'h80, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h3C01_1234);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_iord = 1'b1; cpu_irwrite = 1'b0; cpu_addr = 32'h400;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #2;
        check("midwait mem_req before rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("midwait rst mem_req", 32'(mem_req), 32'd0);
        check("midwait rst instr", instr, 32'h0);
        check("midwait rst mdr", mdr, 32'h0);
        check("midwait rst err", 32'(err), 32'd0);
        check("midwait rst clk_en", 32'(clk_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_instr = '0; exp_mdr = '0;
        #3;
        check("post-rst pass clk_en", 32'(clk_en), 32'd1);
        @(posedge clk); #1;

        run_txn("timeout", 32'h500, 32'h0, 1'b0, 1'b1, 1'b0, 1000, 32'h0, low, high, ecyc);
        check("timeout err cycle", 32'(ecyc), 32'(MW + 1));
        check("timeout no advance", 32'(high), 32'd0);
        for (int c = 0; c < 3; c++) begin
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; cpu_req = 1'(c & 1);
            #4;
            check($sformatf("halt clk_en %0d", c), 32'(clk_en), 32'd0);
            check($sformatf("halt mem_req %0d", c), 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0; cpu_req = 1'b0;
        check("halt late ack mdr", mdr, 32'h0);
        check("halt err sticky", 32'(err), 32'd1);
        apply_reset();
        #3;
        check("after halt reset err", 32'(err), 32'd0);
        check("after halt reset clk_en", 32'(clk_en), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
